arc4_sched: RTL

//  Sequencer and S-memory arbiter for one ARC4 pass: runs init -> ksa -> prga in order.

---
 rtl/arc4_sched.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/arc4_sched.sv
// arc4_sched: sequences one ARC4 pass (init -> ksa -> prga) and arbitrates
// the single-port S memory between the active engine and the host port.
// A per-phase watchdog aborts the pass with err=1 if an engine never finishes.
module arc4_sched #(
   parameter int WAIT_LIMIT = 4096,
   parameter bit RUN_PRGA   = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        rdy,
   input  logic [23:0] key,
   output logic        err,
   output logic [23:0] key_q,
   output logic        init_en,
   output logic        ksa_en,
   output logic        prga_en,
   input  logic        init_rdy,
   input  logic        ksa_rdy,
   input  logic        prga_rdy,
   input  logic [7:0]  init_addr,
   input  logic [7:0]  init_wrdata,
   input  logic        init_wren,
   input  logic [7:0]  ksa_addr,
   input  logic [7:0]  ksa_wrdata,
   input  logic        ksa_wren,
   input  logic [7:0]  prga_addr,
   input  logic [7:0]  prga_wrdata,
   input  logic        prga_wren,
   input  logic [7:0]  host_addr,
   input  logic [7:0]  host_wrdata,
   input  logic        host_wren,
   output logic [7:0]  s_addr,
   output logic [7:0]  s_wrdata,
   output logic        s_wren,
   input  logic [7:0]  rddata
);

   typedef enum logic [2:0] {
      IDLE,
      START_INIT,
      WAIT_INIT,
      START_KSA,
      WAIT_KSA,
      START_PRGA,
      WAIT_PRGA,
      DONE
   } state_e;

   localparam logic [12:0] WDOG_LAST = 13'(WAIT_LIMIT - 1);

   state_e      state_q;
   logic        seen_busy_q;
   logic [12:0] wdog_q;

   logic        cur_rdy;
   logic        wait_done;
   logic        wdog_hit;
   state_e      after_wait;

   // Memory read data is wired straight to the engines and host outside this
   // block; it is only a pass-through port here.
   logic        unused_rddata;
   assign unused_rddata = ^rddata;

   assign rdy = (state_q == IDLE);

   // Select the ready flag of the engine owning the current phase and the
   // state that follows its completion.
   always_comb begin
      cur_rdy    = 1'b0;
      after_wait = DONE;
      case (state_q)
         START_INIT, WAIT_INIT: begin
            cur_rdy    = init_rdy;
            after_wait = START_KSA;
         end
         START_KSA, WAIT_KSA: begin
            cur_rdy    = ksa_rdy;
            after_wait = RUN_PRGA ? START_PRGA : DONE;
         end
         START_PRGA, WAIT_PRGA: begin
            cur_rdy    = prga_rdy;
            after_wait = DONE;
         end
         default: ;
      endcase
   end

   // A phase is only complete once the engine has been seen busy, so a
   // stale ready from before the start pulse cannot end the phase early.
   assign wait_done = cur_rdy && seen_busy_q;
   assign wdog_hit  = (wdog_q == WDOG_LAST);

   // Pass sequencer: start pulses, busy tracking, watchdog and key latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         err         <= 1'b0;
         key_q       <= 24'h0;
         init_en     <= 1'b0;
         ksa_en      <= 1'b0;
         prga_en     <= 1'b0;
         seen_busy_q <= 1'b0;
         wdog_q      <= 13'h0;
      end else begin
         init_en <= 1'b0;
         ksa_en  <= 1'b0;
         prga_en <= 1'b0;
         case (state_q)
            IDLE: begin
               if (en) begin
                  key_q   <= key;
                  err     <= 1'b0;
                  state_q <= START_INIT;
               end
            end
            START_INIT, START_KSA, START_PRGA: begin
               if (cur_rdy) begin
                  init_en     <= (state_q == START_INIT);
                  ksa_en      <= (state_q == START_KSA);
                  prga_en     <= (state_q == START_PRGA);
                  seen_busy_q <= 1'b0;
                  wdog_q      <= 13'h0;
                  state_q     <= state_e'(state_q + 3'd1);
               end
            end
            WAIT_INIT, WAIT_KSA, WAIT_PRGA: begin
               if (!cur_rdy) begin
                  seen_busy_q <= 1'b1;
               end
               if (wait_done) begin
                  state_q <= after_wait;
               end else if (wdog_hit) begin
                  err     <= 1'b1;
                  state_q <= DONE;
               end else begin
                  wdog_q <= wdog_q + 13'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // S memory port follows the owner of the current state; everyone else's
   // writes are simply not routed.
   always_comb begin
      s_addr   = host_addr;
      s_wrdata = host_wrdata;
      s_wren   = host_wren;
      case (state_q)
         START_INIT, WAIT_INIT: begin
            s_addr   = init_addr;
            s_wrdata = init_wrdata;
            s_wren   = init_wren;
         end
         START_KSA, WAIT_KSA: begin
            s_addr   = ksa_addr;
            s_wrdata = ksa_wrdata;
            s_wren   = ksa_wren;
         end
         START_PRGA, WAIT_PRGA: begin
            s_addr   = prga_addr;
            s_wrdata = prga_wrdata;
            s_wren   = prga_wren;
         end
         default: ;
      endcase
   end

endmodule
